// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 16 request lines; issues the winner as a 4-bit index
// with an offer/accept handshake and held grant. Optional watchdog: ARB_TIMEOUT_EN.
module rr_index_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        gnt_ready,
  input  logic        done,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic        gnt_active,
  output logic        tout
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic [3:0]  idx_reg, idx_next;
  logic        tout_reg, tout_next;
  logic        timeout_hit;

  // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
  logic [15:0] upper_req;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_upper
      assign upper_req[gi] = req[gi] & (4'(gi) >= ptr_reg);
    end
  endgenerate

  logic [3:0] upper_idx, any_idx, sel_idx;
  logic       upper_hit;

  always_comb begin
    upper_idx = 4'd0;
    upper_hit = 1'b0;
    any_idx   = 4'd0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = 15; i >= 0; i--) begin
      if (upper_req[i]) begin
        upper_idx = 4'(i);
        upper_hit = 1'b1;
      end
      if (req[i]) begin
        any_idx = 4'(i);
      end
    end
    sel_idx = upper_hit ? upper_idx : any_idx;
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wd_reg, wd_next;

  always_comb begin
    wd_next     = (state_reg == HOLD) ? wd_reg + 8'd1 : 8'd0;
    timeout_hit = (state_reg == HOLD) && !done && (wd_reg + 8'd1 == 8'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_reg <= 8'd0;
    end else begin
      wd_reg <= wd_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    tout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          idx_next   = sel_idx;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (gnt_ready) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        // done outranks the watchdog, so tout only fires on a forced release.
        if (done || timeout_hit) begin
          state_next = IDLE;
          ptr_next   = idx_reg + 4'd1;
          tout_next  = timeout_hit;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 4'd0;
      idx_reg   <= 4'd0;
      tout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      tout_reg  <= tout_next;
    end
  end

  assign gnt_valid  = (state_reg == ISSUE);
  assign gnt_active = (state_reg == HOLD);
  assign gnt_idx    = idx_reg;
  assign tout       = tout_reg;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: directed scenarios plus randomized
// transactions checked against a cyclic-scan reference model.
module tb_rr_index_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        gnt_ready;
  logic        done;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic        gnt_active;
  logic        tout;

  int checks;
  int errors;
  int mptr;

  rr_index_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_active(gnt_active),
    .tout      (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: first requesting line scanning ptr, ptr+1, ... modulo 16.
  function automatic int model_pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = 16'h0;
    gnt_ready = 1'b0;
    done = 1'b0;
    #3;
    step();
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({gnt_valid, gnt_idx, gnt_active, tout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b i=%0d a=%0b t=%0b want all 0", gnt_valid, gnt_idx, gnt_active, tout);
    end
    step();
    checks++;
    if (gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got valid=%0b want 0", gnt_valid);
    end
  endtask

  task automatic test_basic();
    req = 16'h0001;
    gnt_ready = 1'b1;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd0) begin
      errors++;
      $display("FAIL basic_offer got v=%0b i=%0d want v=1 i=0", gnt_valid, gnt_idx);
    end
    step();
    checks++;
    if (gnt_active !== 1'b1 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold got a=%0b v=%0b want a=1 v=0", gnt_active, gnt_valid);
    end
    done = 1'b1;
    req = 16'h0;
    step();
    done = 1'b0;
    checks++;
    if (gnt_active !== 1'b0 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got a=%0b v=%0b want 0 0", gnt_active, gnt_valid);
    end
    // ptr must now be 1: line 1 beats line 0.
    req = 16'h0003;
    gnt_ready = 1'b0;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd1) begin
      errors++;
      $display("FAIL basic_ptr got v=%0b i=%0d want v=1 i=1", gnt_valid, gnt_idx);
    end
    gnt_ready = 1'b1;
    step();
    done = 1'b1;
    req = 16'h0;
    step();
    done = 1'b0;
    $display("basic: grants 0 then 1 done");
  endtask

  task automatic test_fairness();
    apply_reset();
    req = 16'hFFFF;
    gnt_ready = 1'b1;
    done = 1'b1;
    for (int n = 0; n < 17; n++) begin
      step();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 4'(n % 16)) begin
        errors++;
        $display("FAIL fairness_seq%0d got v=%0b i=%0d want v=1 i=%0d", n, gnt_valid, gnt_idx, n % 16);
      end
      step();
      step();
    end
    // Last grant 0 released; ptr is now 1.
    mptr = 1;
    req = 16'h0;
    done = 1'b0;
    step();
    $display("fairness: 17 grants in order");
  endtask

  task automatic test_wrap();
    // Serve line 13 so ptr becomes 14, then check wrap to 0 then 1.
    logic [3:0] want [3];
    logic [15:0] reqs [3];
    reqs[0] = 16'h2000; want[0] = 4'd13;
    reqs[1] = 16'h0003; want[1] = 4'd0;
    reqs[2] = 16'h0003; want[2] = 4'd1;
    gnt_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      req = reqs[n];
      step();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== want[n]) begin
        errors++;
        $display("FAIL wrap_%0d got v=%0b i=%0d want v=1 i=%0d", n, gnt_valid, gnt_idx, want[n]);
      end
      req = 16'h0;
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      $display("wrap: grant %0d", gnt_idx);
    end
    mptr = 2;
  endtask

  task automatic test_stall();
    req = 16'h0010;
    gnt_ready = 1'b0;
    step();
    req = 16'h0;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 4'd4 || gnt_active !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got v=%0b i=%0d a=%0b want v=1 i=4 a=0", n, gnt_valid, gnt_idx, gnt_active);
      end
    end
    gnt_ready = 1'b1;
    step();
    checks++;
    if (gnt_active !== 1'b1 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept got a=%0b v=%0b want a=1 v=0", gnt_active, gnt_valid);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    mptr = 5;
    $display("stall: grant 4 held through 5 stall cycles");
  endtask

  task automatic test_watchdog();
    for (int pass = 0; pass < 2; pass++) begin
      req = 16'h0100;
      gnt_ready = 1'b1;
      step();
      req = 16'h0;
      step();  // entered HOLD
      for (int n = 0; n < 3; n++) begin
        step();
        checks++;
        if (gnt_active !== 1'b1 || tout !== 1'b0) begin
          errors++;
          $display("FAIL wd_hold_%0d_%0d got a=%0b t=%0b want a=1 t=0", pass, n, gnt_active, tout);
        end
      end
      done = (pass == 1);
      step();  // fourth HOLD edge
      done = 1'b0;
`ifdef ARB_TIMEOUT_EN
      checks++;
      if (gnt_active !== 1'b0 || tout !== (pass == 0)) begin
        errors++;
        $display("FAIL wd_edge_%0d got a=%0b t=%0b want a=0 t=%0b", pass, gnt_active, tout, pass == 0);
      end
      step();
      checks++;
      if (tout !== 1'b0) begin
        errors++;
        $display("FAIL wd_pulse_%0d got t=%0b want 0", pass, tout);
      end
`else
      checks++;
      if (gnt_active !== (pass == 0) || tout !== 1'b0) begin
        errors++;
        $display("FAIL wd_off_%0d got a=%0b t=%0b want a=%0b t=0", pass, gnt_active, tout, pass == 0);
      end
      if (pass == 0) begin
        for (int n = 0; n < 6; n++) step();
        checks++;
        if (gnt_active !== 1'b1 || tout !== 1'b0) begin
          errors++;
          $display("FAIL wd_off_wait got a=%0b t=%0b want a=1 t=0", gnt_active, tout);
        end
        done = 1'b1;
        step();
        done = 1'b0;
      end
`endif
      $display("watchdog: pass %0d done", pass);
    end
    mptr = 9;
  endtask

  task automatic test_reset_mid_hold();
    req = 16'h0200;
    gnt_ready = 1'b1;
    step();
    req = 16'h0;
    step();
    checks++;
    if (gnt_active !== 1'b1 || gnt_idx !== 4'd9) begin
      errors++;
      $display("FAIL rst_setup got a=%0b i=%0d want a=1 i=9", gnt_active, gnt_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt_valid, gnt_idx, gnt_active, tout} !== 7'b0) begin
      errors++;
      $display("FAIL rst_async got v=%0b i=%0d a=%0b t=%0b want all 0", gnt_valid, gnt_idx, gnt_active, tout);
    end
    step();
    rst = 1'b0;
    mptr = 0;
    req = 16'hFFFF;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 4'd0 || tout !== 1'b0) begin
      errors++;
      $display("FAIL rst_regrant got v=%0b i=%0d t=%0b want v=1 i=0 t=0", gnt_valid, gnt_idx, tout);
    end
    req = 16'h0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    mptr = 1;
    $display("reset: mid-hold reset then regrant 0");
  endtask

  task automatic test_random();
    logic [15:0] r;
    int exp_idx;
    int stall;
    int wait_hold;
    for (int t = 0; t < 40; t++) begin
      for (int n = 0; n < $urandom_range(0, 2); n++) begin
        req = 16'h0;
        gnt_ready = 1'($urandom_range(0, 1));
        step();
        checks++;
        if (gnt_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle_%0d got v=%0b want 0", t, gnt_valid);
        end
      end
      r = 16'($urandom);
      if (r == 16'h0) r = 16'h8000;
      req = r;
      gnt_ready = 1'b0;
      exp_idx = model_pick(r, mptr);
      step();
      stall = $urandom_range(0, 3);
      for (int n = 0; n <= stall; n++) begin
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 4'(exp_idx)) begin
          errors++;
          $display("FAIL rand_offer_%0d got v=%0b i=%0d want v=1 i=%0d", t, gnt_valid, gnt_idx, exp_idx);
        end
        req = 16'($urandom);
        done = 1'($urandom_range(0, 1));
        gnt_ready = (n == stall);
        step();
      end
      wait_hold = $urandom_range(0, 2);
      for (int n = 0; n <= wait_hold; n++) begin
        checks++;
        if (gnt_active !== 1'b1 || gnt_valid !== 1'b0 || gnt_idx !== 4'(exp_idx)) begin
          errors++;
          $display("FAIL rand_hold_%0d got a=%0b v=%0b i=%0d want a=1 v=0 i=%0d", t, gnt_active, gnt_valid, gnt_idx, exp_idx);
        end
        req = 16'($urandom);
        gnt_ready = 1'($urandom_range(0, 1));
        done = (n == wait_hold);
        step();
      end
      done = 1'b0;
      checks++;
      if (gnt_active !== 1'b0 || tout !== 1'b0) begin
        errors++;
        $display("FAIL rand_release_%0d got a=%0b t=%0b want a=0 t=0", t, gnt_active, tout);
      end
      mptr = (exp_idx + 1) % 16;
      $display("rand txn %0d: req=%h grant=%0d stall=%0d hold=%0d", t, r, exp_idx, stall, wait_hold);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mptr = 0;
    test_reset();
    test_basic();
    test_fairness();
    test_wrap();
    test_stall();
    test_watchdog();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
